// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter that serialises 1/2-byte messages
// from N_REQ requesters onto the shared TX FIFO write port.
module tx_fifo_arbiter #(
  parameter int Data_W = 8,
  parameter int N_REQ  = 3,
  parameter int ID_W   = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ARB_EN,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ-1:0]          REQ_LEN,
  input  logic [N_REQ*2*Data_W-1:0] REQ_DATA,
  input  logic                      FIFO_FULL,
  output logic                      W_INC,
  output logic [Data_W-1:0]         WR_DATA,
  output logic [N_REQ-1:0]          ACK,
  output logic                      BUSY,
  output logic [ID_W-1:0]           GNT_ID
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_LO,
    SEND_HI
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     gnt_q;
  logic [ID_W-1:0]     ptr_nxt;
  logic [ID_W-1:0]     win_idx;
  logic                win_vld;
  logic [2*Data_W-1:0] data_q;
  logic                len_q;
  logic                grant;
  logic                wr_ok;
  logic                last_wr;
  logic [2*Data_W-1:0] msg [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_msg
    assign msg[i] = REQ_DATA[i*2*Data_W +: 2*Data_W];
  end

  // Scan from the far end so the lowest offset from ptr wins.
  always_comb begin : pick
    logic [ID_W-1:0] k;
    win_vld = 1'b0;
    win_idx = '0;
    k       = '0;
    for (int j = N_REQ-1; j >= 0; j--) begin
      k = ID_W'((int'(ptr_q) + j) % N_REQ);
      if (REQ[k]) begin
        win_vld = 1'b1;
        win_idx = k;
      end
    end
  end

  assign grant   = (state_q == IDLE) && ARB_EN && win_vld;
  assign wr_ok   = (state_q != IDLE) && !FIFO_FULL;
  assign last_wr = wr_ok && ((state_q == SEND_HI) || !len_q);
  assign ptr_nxt = (gnt_q == ID_W'(N_REQ-1)) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge CLK) begin : state_reg
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin : ctx_reg
    if (RST) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      data_q <= '0;
      len_q  <= 1'b0;
    end else begin
      if (grant) begin
        data_q <= msg[win_idx];
        len_q  <= REQ_LEN[win_idx];
        gnt_q  <= win_idx;
      end
      if (last_wr) ptr_q <= ptr_nxt;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = SEND_LO;
      SEND_LO: if (wr_ok) state_d = len_q ? SEND_HI : IDLE;
      SEND_HI: if (wr_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    W_INC   = wr_ok && !RST;
    ACK     = (last_wr && !RST) ? (N_REQ'(1) << gnt_q) : '0;
    WR_DATA = (state_q == SEND_HI) ? data_q[2*Data_W-1:Data_W]
                                   : data_q[Data_W-1:0];
    BUSY    = (state_q != IDLE);
  end

  assign GNT_ID = gnt_q;

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Bench for tx_fifo_arbiter: directed scenarios plus
// randomized traffic against a queue-based message model.
module tb_tx_fifo_arbiter;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic            ARB_EN;
  logic [N-1:0]    REQ;
  logic [N-1:0]    REQ_LEN;
  logic [N*2*DW-1:0] REQ_DATA;
  logic            FIFO_FULL;
  logic            W_INC;
  logic [DW-1:0]   WR_DATA;
  logic [N-1:0]    ACK;
  logic            BUSY;
  logic [IW-1:0]   GNT_ID;

  tx_fifo_arbiter #(.Data_W(DW), .N_REQ(N), .ID_W(IW)) dut (
    .CLK(CLK), .RST(RST), .ARB_EN(ARB_EN),
    .REQ(REQ), .REQ_LEN(REQ_LEN), .REQ_DATA(REQ_DATA),
    .FIFO_FULL(FIFO_FULL), .W_INC(W_INC), .WR_DATA(WR_DATA),
    .ACK(ACK), .BUSY(BUSY), .GNT_ID(GNT_ID)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Model: the in-flight message is a queue of bytes still owed.
  logic [DW-1:0] mq[$];
  int m_owner = 0;
  int m_ptr   = 0;
  bit m_valid = 0;

  always @(negedge CLK) begin
    if (m_valid) begin
      bit e_winc;
      e_winc = !RST && (mq.size() > 0) && !FIFO_FULL;
      chk("m_winc", W_INC, e_winc);
      chk("m_busy", BUSY, mq.size() > 0);
      chk("m_gnt", GNT_ID, m_owner);
      chk("m_ack", ACK,
          (e_winc && mq.size() == 1) ? (1 << m_owner) : 0);
      if (mq.size() > 0) chk("m_data", WR_DATA, mq[0]);
    end
  end

  always @(posedge CLK) begin
    if (RST) begin
      mq.delete();
      m_ptr   = 0;
      m_owner = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (mq.size() == 0) begin
        if (ARB_EN && |REQ) begin
          for (int j = 0; j < N; j++) begin
            if (REQ[(m_ptr + j) % N]) begin
              m_owner = (m_ptr + j) % N;
              break;
            end
          end
          mq.push_back(REQ_DATA[m_owner*2*DW +: DW]);
          if (REQ_LEN[m_owner])
            mq.push_back(REQ_DATA[m_owner*2*DW + DW +: DW]);
        end
      end else if (!FIFO_FULL) begin
        mq.delete(0);
        if (mq.size() == 0) m_ptr = (m_owner + 1) % N;
      end
    end
  end

  logic [N-1:0] ackd;

  initial begin
    RST = 1'b1; ARB_EN = 1'b1; FIFO_FULL = 1'b0;
    REQ = '0; REQ_LEN = '0; REQ_DATA = '0;
    ackd = '0;
    step(); step();
    chk("rst_winc", W_INC, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_data", WR_DATA, 0);
    chk("rst_gnt", GNT_ID, 0);

    // single byte from requester 1
    RST = 1'b0; REQ = 3'b010;
    REQ_DATA = 48'h0000_00A5_0000;
    #1 chk("t1_idle_winc", W_INC, 0);
    step();
    chk("t1_winc", W_INC, 1);
    chk("t1_data", WR_DATA, 8'hA5);
    chk("t1_ack", ACK, 3'b010);
    chk("t1_busy", BUSY, 1);
    chk("t1_gnt", GNT_ID, 1);
    chk("pin_owner1", m_owner, 1);
    chk("pin_qlen1", mq.size(), 1);
    REQ = '0;
    step();
    chk("t1_busy_end", BUSY, 0);

    // two bytes with a 3-cycle stall on the high byte
    REQ = 3'b001; REQ_LEN = 3'b001; REQ_DATA = 48'h1234;
    #1 step();
    chk("t2_lo_winc", W_INC, 1);
    chk("t2_lo_data", WR_DATA, 8'h34);
    chk("t2_lo_ack", ACK, 0);
    step();
    FIFO_FULL = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_winc", W_INC, 0);
      chk("t2_stall_ack", ACK, 0);
      chk("t2_stall_busy", BUSY, 1);
      step();
    end
    FIFO_FULL = 1'b0;
    #1;
    chk("t2_hi_winc", W_INC, 1);
    chk("t2_hi_data", WR_DATA, 8'h12);
    chk("t2_hi_ack", ACK, 3'b001);
    REQ = '0; REQ_LEN = '0;
    step();
    chk("t2_busy_end", BUSY, 0);

    // everyone requesting from reset: strict rotation
    RST = 1'b1;
    step();
    RST = 1'b0; REQ = 3'b111;
    REQ_DATA = {16'h0012, 16'h0011, 16'h0010};
    #1;
    for (int m = 0; m < 6; m++) begin
      chk("t3_bubble", BUSY, 0);
      step();
      chk("t3_gnt", GNT_ID, m % 3);
      chk("t3_data", WR_DATA, 8'h10 + (m % 3));
      chk("t3_ack", ACK, 1 << (m % 3));
      chk("pin_owner3", m_owner, m % 3);
      step();
    end
    REQ = '0;

    // inputs change right after grant; latched copy is sent
    REQ = 3'b100; REQ_LEN = 3'b100;
    REQ_DATA = {16'hBEEF, 32'h0};
    #1 step();
    REQ_DATA = '0; REQ = '0;
    #1;
    chk("t4_lo_winc", W_INC, 1);
    chk("t4_lo_data", WR_DATA, 8'hEF);
    chk("t4_lo_ack", ACK, 0);
    step();
    chk("t4_hi_data", WR_DATA, 8'hBE);
    chk("t4_hi_ack", ACK, 3'b100);
    step();
    chk("t4_idle_winc", W_INC, 0);
    step();
    chk("t4_no_reack", ACK, 0);
    REQ_LEN = '0;

    // arbitration disabled
    ARB_EN = 1'b0; REQ = 3'b111;
    REQ_DATA = {16'h0033, 16'h0022, 16'h0011};
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_off_winc", W_INC, 0);
      chk("t5_off_busy", BUSY, 0);
      step();
    end
    ARB_EN = 1'b1;
    step();
    chk("t5_gnt", GNT_ID, 0);
    chk("t5_busy", BUSY, 1);
    chk("t5_data", WR_DATA, 8'h11);
    REQ = '0;
    step();

    // reset in SEND_HI drops the message
    REQ = 3'b010; REQ_LEN = 3'b010;
    REQ_DATA = {16'h0000, 16'h5678, 16'h0000};
    #1 step();
    chk("t6_lo_data", WR_DATA, 8'h78);
    step();
    RST = 1'b1; REQ = 3'b100; REQ_LEN = '0;
    REQ_DATA = {16'h00C3, 32'h0};
    #1;
    chk("t6_rst_winc", W_INC, 0);
    chk("t6_rst_ack", ACK, 0);
    step();
    chk("t6_post_busy", BUSY, 0);
    chk("t6_post_winc", W_INC, 0);
    RST = 1'b0;
    #1 step();
    chk("t6_gnt", GNT_ID, 2);
    chk("t6_data", WR_DATA, 8'hC3);
    chk("t6_ack", ACK, 3'b100);
    REQ = '0;
    step();

    // randomized traffic; requesters mostly follow the protocol
    for (int c = 0; c < 3000; c++) begin
      RST       = ($urandom_range(0, 199) == 0);
      ARB_EN    = ($urandom_range(0, 7) != 0);
      FIFO_FULL = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        if (ackd[i])
          REQ[i] = 1'($urandom_range(0, 1));
        else if (!REQ[i])
          REQ[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 31) == 0)
          REQ[i] = 1'b0;
      end
      REQ_LEN  = N'($urandom);
      REQ_DATA = {16'($urandom), $urandom};
      #1;
      ackd = ACK;
      step();
    end

    RST = 1'b0; REQ = '0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fifo_arbiter.md
Name: tx_fifo_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single TX async-FIFO write port (W_INC/WR_DATA) between N_REQ requesters, such as the ALU result path, the register-read path and the status/error reporter. Each requester submits a 1- or 2-byte message; the arbiter serialises it into the FIFO one byte per cycle, low byte first. It stalls on FIFO_FULL and acknowledges the requester when its last byte is written. It runs in the REF_CLK domain and sits between SYS_CTRL-side producers and Async_fifo.

Parameters:
Data_W, 8, byte width written to the FIFO
N_REQ, 3, number of requesters (2..8)
ID_W, 2, width of GNT_ID; must be >= clog2(N_REQ)

Ports:
CLK  input  1  REF_CLK-domain clock
RST  input  1  synchronous, active-high reset
ARB_EN  input  1  1 = new grants allowed; 0 = no new grant, but an in-flight message completes
REQ  input  N_REQ  per-requester request level; held until the matching ACK
REQ_LEN  input  N_REQ  per-requester length: 0 = 1 byte, 1 = 2 bytes
REQ_DATA  input  N_REQ*2*Data_W  requester i message at [(2i+2)*Data_W-1 : 2i*Data_W], low byte in the lower half
FIFO_FULL  input  1  FIFO full flag (write side)
W_INC  output  1  FIFO write strobe
WR_DATA  output  Data_W  FIFO write data
ACK  output  N_REQ  one-hot, 1-cycle pulse when a requester's final byte is written
BUSY  output  1  message in flight (state != IDLE)
GNT_ID  output  ID_W  index of the current/last granted requester

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, SEND_LO, SEND_HI. State, the data register, the length bit, GNT_ID and the priority pointer PTR are all registered.
- Reset values (on any CLK edge with RST=1): state=IDLE, PTR=0, GNT_ID=0, data register=0, length=0. Outputs W_INC=0, ACK=0, BUSY=0, WR_DATA=0.
- W_INC and ACK are forced to 0 combinationally while RST=1.
- IDLE, grant selection:
  - A grant happens if ARB_EN=1 and |REQ.
  - The winner is the first i with REQ[i]=1, searching PTR, PTR+1, ... mod N_REQ.
  - On the grant edge: latch REQ_DATA slice i and REQ_LEN[i], set GNT_ID=i, go to SEND_LO.
  - No W_INC is issued in IDLE.
- SEND_LO:
  - WR_DATA = latched low byte.
  - W_INC = !FIFO_FULL (combinational from the registered state and FIFO_FULL).
  - If FIFO_FULL=1: hold state, no ACK.
  - If FIFO_FULL=0 and length=1: go to SEND_HI.
  - If FIFO_FULL=0 and length=0: ACK[GNT_ID]=1 this cycle; next state IDLE; PTR=(GNT_ID+1) mod N_REQ.
- SEND_HI: WR_DATA = latched high byte; same stall and W_INC rules as SEND_LO. On the write: ACK[GNT_ID]=1, go to IDLE, update PTR.
- Latency: REQ sampled in IDLE at edge k; first W_INC in cycle k+1 at the earliest.
- Throughput: a 2-byte message writes on consecutive cycles when not full. One mandatory IDLE bubble follows every message.
- ACK is coincident with the final W_INC. The requester must drop REQ at that edge (or present a new message, which is arbitrated normally in the following IDLE).
- Changes to REQ, REQ_LEN or REQ_DATA after the grant are ignored until return to IDLE. Deassertion of REQ mid-message does not abort it.
- FIFO_FULL can toggle each cycle; exactly one W_INC is issued per byte and no byte is skipped or duplicated.
- ARB_EN=0 while in SEND_*: the message completes. ARB_EN is only consulted in IDLE.
- GNT_ID holds its value in IDLE. BUSY = (state != IDLE).
- Requests with index >= N_REQ do not exist; PTR wraps from N_REQ-1 to 0.
- Reset mid-message: the message is dropped with no ACK, the FIFO receives no further bytes, and PTR=0.

Test Plan:
1. REQ[1]=1, REQ_LEN[1]=0, byte 0xA5, FIFO_FULL=0 -> one W_INC with WR_DATA=0xA5 in the cycle after the grant; ACK=3'b010 in the same cycle; BUSY high for exactly 1 cycle.
2. REQ[0] 2-byte 0x1234, with FIFO_FULL=1 for 3 cycles during SEND_HI -> 0x34 written, then W_INC=0 for 3 cycles, then 0x12 written; ACK[0] coincident with the 0x12 write; exactly 2 W_INC total.
3. All REQ high from reset, each holding a distinct 1-byte value and re-requesting immediately after its ACK -> grant order 0,1,2,0,1,2; one IDLE cycle between messages.
4. Grant to requester 2 (2-byte 0xBEEF), then REQ_DATA changed to 0x0000 and REQ[2] dropped one cycle after the grant -> FIFO receives 0xEF, 0xBE; ACK[2] pulses once.
5. ARB_EN=0 with REQ=3'b111 -> no W_INC, BUSY=0. Raising ARB_EN grants requester 0 on the next edge.
6. RST asserted during SEND_HI -> W_INC=0 from that cycle onward, no ACK. After release, a pending REQ[2] alone is granted first and PTR restarts at 0.
